// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and imem: request channel plus in-order response channel.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: fetch PC, imem request issue, circular fetch buffer and redirect flush with stale-response dropping.
module fetch_unit #(
  parameter int unsigned      WIDTH           = 32,
  parameter logic [WIDTH-1:0] RESET_PC        = '0,
  parameter int unsigned      FBUF_DEPTH      = 4,
  parameter int unsigned      MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCSel_EX,
  input  logic [WIDTH-1:0] target_EX,
  input  logic             stall_ID,
  fetch_unit_if.master     imem,
  output logic             valid_IF,
  output logic [31:0]      instr_IF,
  output logic [WIDTH-1:0] pc_IF
);

  localparam int unsigned PTR_W = $clog2(FBUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [WIDTH-1:0]      pc_mem    [FBUF_DEPTH];
  logic [31:0]           instr_mem [FBUF_DEPTH];
  logic [FBUF_DEPTH-1:0] filled_q, filled_d;
  logic [PTR_W:0]        alloc_q, alloc_d;
  logic [PTR_W:0]        fill_q, fill_d;
  logic [PTR_W:0]        head_q, head_d;
  logic [CNT_W-1:0]      live_q, live_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [WIDTH-1:0]      pc_q, pc_d;

  logic [PTR_W:0]   occupancy;
  logic [CNT_W:0]   inflight;
  logic [PTR_W-1:0] alloc_idx, fill_idx, head_idx;
  logic             req_fire, rsp_known, rsp_fill, head_ok, consume;
  logic             unused_tgt;

  assign unused_tgt = ^target_EX[1:0];

  assign alloc_idx = alloc_q[PTR_W-1:0];
  assign fill_idx  = fill_q[PTR_W-1:0];
  assign head_idx  = head_q[PTR_W-1:0];
  assign occupancy = alloc_q - head_q;
  assign inflight  = {1'b0, live_q} + {1'b0, drop_q};

  // Request issue is independent of stall_ID; a full buffer or full in-flight budget holds it off.
  assign imem.imem_req_valid = !rst && !PCSel_EX &&
                               (occupancy < (PTR_W+1)'(FBUF_DEPTH)) &&
                               (inflight < (CNT_W+1)'(MAX_OUTSTANDING));
  assign imem.imem_req_addr  = pc_q;

  assign req_fire  = imem.imem_req_valid && imem.imem_req_ready;
  // Responses with nothing outstanding are protocol errors and are ignored.
  assign rsp_known = imem.imem_rsp_valid && (inflight != '0);
  assign rsp_fill  = rsp_known && !PCSel_EX && (drop_q == '0);

  assign head_ok  = (occupancy != '0) && filled_q[head_idx];
  assign valid_IF = head_ok && !PCSel_EX;
  assign consume  = valid_IF && !stall_ID;
  assign instr_IF = valid_IF ? instr_mem[head_idx] : NOP;
  assign pc_IF    = valid_IF ? pc_mem[head_idx] : '0;

  // Next-state: redirect flushes the buffer and moves live requests to the drop pool.
  always_comb begin
    pc_d     = pc_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    head_d   = head_q;
    filled_d = filled_q;
    live_d   = live_q;
    drop_d   = drop_q;
    if (PCSel_EX) begin
      pc_d     = {target_EX[WIDTH-1:2], 2'b00};
      alloc_d  = '0;
      fill_d   = '0;
      head_d   = '0;
      filled_d = '0;
      live_d   = '0;
      drop_d   = drop_q + live_q - CNT_W'(rsp_known);
    end else begin
      if (req_fire) begin
        pc_d    = pc_q + WIDTH'(4);
        alloc_d = alloc_q + (PTR_W+1)'(1);
      end
      if (rsp_known) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          fill_d             = fill_q + (PTR_W+1)'(1);
          filled_d[fill_idx] = 1'b1;
        end
      end
      if (consume) begin
        head_d             = head_q + (PTR_W+1)'(1);
        filled_d[head_idx] = 1'b0;
      end
      live_d = live_q + CNT_W'(req_fire) - CNT_W'(rsp_fill);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      filled_q <= '0;
      live_q   <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      filled_q <= filled_d;
      live_q   <= live_d;
      drop_q   <= drop_d;
    end
  end

  // Buffer payload: PC captured at accept, instruction at fill; validity lives in filled_q.
  always_ff @(posedge clk) begin
    if (req_fire) pc_mem[alloc_idx] <= pc_q;
    if (rsp_fill) instr_mem[fill_idx] <= imem.imem_rsp_data;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the pipelined RV32I core. Directly upstream of decode, and consumer of the EX-stage branch decision (PCSel) and its redirect target.
- Holds the fetch PC and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs and presents them to ID.
- On a taken branch or jump, flushes wrong-path state and silently drops stale in-flight responses.

Parameters:
WIDTH, 32, address/PC width
RESET_PC, 32'h0000_0000, first fetch address after reset
FBUF_DEPTH, 4, fetch buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 4, max imem requests in flight, live plus dropping (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset
PCSel_EX  in  1  redirect request from EX (branch taken / JAL / JALR)
target_EX  in  WIDTH  redirect address; bits[1:0] forced to 0 internally
stall_ID  in  1  ID cannot accept this cycle
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  WIDTH  word-aligned fetch address
imem_rsp_valid  in  1  response valid; in order, one per accepted request
imem_rsp_data  in  32  instruction word
valid_IF  out  1  instr_IF/pc_IF valid to ID
instr_IF  out  32  instruction at buffer head
pc_IF  out  WIDTH  PC of instr_IF

Behaviour:
- Reset is synchronous and active-high on rst. Single clock, clk.
- Reset values: fetch PC = RESET_PC; buffer empty; live and drop counters = 0; imem_req_valid = 0; valid_IF = 0.
- Whenever valid_IF=0: instr_IF = 32'h0000_0013 (NOP) and pc_IF = 0.
- Fetch buffer: circular, FBUF_DEPTH entries {pc, instr, filled}, with three pointers:
  - alloc: advances on request accept; entry pc is written at accept.
  - fill: advances on each non-dropped response; writes instr and sets filled.
  - head: advances on consume.
- Occupancy = allocated, not yet consumed.
- imem_req_valid = !rst && !PCSel_EX && occupancy < FBUF_DEPTH && (live + drop) < MAX_OUTSTANDING.
  - No dependence on stall_ID; no same-cycle slot reuse.
- imem_req_addr = fetch PC. Accept (valid && ready): fetch PC += 4 (wraps mod 2^WIDTH); live += 1.
- imem_req_valid may deassert without acceptance (redirect). The memory tolerates withdrawn requests.
- Response handling:
  - drop > 0: discard, drop -= 1.
  - Otherwise: write the fill entry, live -= 1.
  - A response with no outstanding request is a protocol error; the block ignores it.
- Output: valid_IF = head entry allocated && filled && !PCSel_EX. No bypass, so a response is visible the cycle after it arrives. Minimum latency is accept at N, response at N+1, valid_IF at N+2.
- Consume on valid_IF && !stall_ID.
- While stall_ID=1, the head is held and outputs stay stable.
- Redirect (PCSel_EX=1 in cycle N):
  - valid_IF forced 0 in cycle N (wrong path); no consume.
  - No request issued in cycle N.
  - At edge N: fetch PC <- {target_EX[WIDTH-1:2],2'b00}; all buffer entries invalidated, pointers reset equal; drop <- drop + live - (1 if response arrived in N); live <- 0.
  - A response arriving in cycle N is discarded regardless of counters.
  - First new-path request is issued in N+1.
- Back-to-back redirects: each takes effect at its own edge; the last target wins. Drop accounting accumulates.
- Throughput: with 1-cycle imem and stall_ID=0, the steady state is one instruction per cycle.
- Counter widths are sized so live+drop <= MAX_OUTSTANDING; no overflow is possible.
- Reset mid-operation: all state is cleared. Responses to pre-reset requests are the memory's responsibility (memory is reset together).

Test Plan:
- Reset release, 1-cycle imem returning addr-as-data, stall_ID=0 → requests 0x0,0x4,0x8… on consecutive cycles; valid_IF first high 2 cycles after first accept, pc_IF/instr_IF 0x0,0x4,0x8 one per cycle, no gaps.
- imem_req_ready=0 for 5 cycles, then 1 → imem_req_addr held at 0x0 throughout; no valid_IF until accept+2; PC sequence continuous.
- stall_ID=1 for 6 cycles with valid_IF high at pc_IF=0x8 → pc_IF stays 0x8; at most 4 entries allocated, imem_req_valid drops when full; after release 0x8,0xC,0x10,0x14 issue consecutively with no skip or duplicate.
- 3-cycle imem latency, 3 requests in flight (0x10,0x14,0x18), PCSel_EX=1, target_EX=0x103 → valid_IF=0 that cycle; next request addr=0x100; the 3 stale responses are dropped; first valid_IF shows pc_IF=0x100 with the matching data.
- Response arrives in the same cycle as PCSel_EX=1, target 0x200 → that response is discarded; drop = live−1; next pc_IF = 0x200.
- PCSel_EX high two consecutive cycles (targets 0x40, then 0x80) → no request to 0x40 is consumed; first valid_IF pc_IF=0x80; rst asserted mid-stream → next cycle valid_IF=0, imem_req_valid=0; after release, fetch restarts at RESET_PC.
